// File: rtl/lsu_pkg.sv
// lsu_pkg: width codes, FSM states and legality helper shared by the load/store unit
package lsu_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} state_t;
  typedef logic [1:0] lane_t;
  function automatic logic legal(input logic we, input logic [2:0] f3, input lane_t off);
    legal = (f3 == F3_B) || (!we && f3 == F3_BU) ||
            ((f3 == F3_H || (!we && f3 == F3_HU)) && !off[0]) ||
            (f3 == F3_W && off == 2'b00);
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: request/response and word-memory signals of the load/store unit
interface lsu_if;
  import lsu_pkg::*;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rw;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_rw
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_rw
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: little-endian load extract/extend and sub-word store merge
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]            funct3,
  input  lane_t                 off,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic [DATA_WIDTH-1:0] st_data
);
  logic [DATA_WIDTH-1:0] sh, mask, rep;
  always_comb begin
    sh = rdata >> {off, 3'b000};
    ld_data = funct3 == F3_B  ? {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]} :
              funct3 == F3_H  ? {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]} :
              funct3 == F3_BU ? {{(DATA_WIDTH-8){1'b0}}, sh[7:0]} :
              funct3 == F3_HU ? {{(DATA_WIDTH-16){1'b0}}, sh[15:0]} : rdata;
    mask = funct3 == F3_B ? 32'h0000_00FF << {off, 3'b000} :
           funct3 == F3_H ? 32'h0000_FFFF << {off[1], 4'b0000} : '1;
    rep = funct3 == F3_B ? {4{wdata[7:0]}} : funct3 == F3_H ? {2{wdata[15:0]}} : wdata;
    st_data = (rdata & ~mask) | (rep & mask);
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: one-at-a-time RV32I load/store sequencer onto a word-only memory
module lsu_ctrl
  import lsu_pkg::*;
(
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);
  state_t                state_q, state_d;
  logic                  we_q, we_d, err_q, err_d, accept;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, ld_data, st_data;
  lsu_align u_align (
    .funct3  (f3_q),
    .off     (addr_q[1:0]),
    .rdata   (bus.mem_rdata),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_data (st_data)
  );
  always_comb begin
    accept  = bus.req_valid && state_q == IDLE;
    we_d    = accept ? bus.req_we : we_q;
    f3_d    = accept ? bus.req_funct3 : f3_q;
    addr_d  = accept ? bus.req_addr : addr_q;
    wdata_d = accept ? bus.req_wdata : wdata_q;
    err_d   = accept ? !legal(bus.req_we, bus.req_funct3, bus.req_addr[1:0]) : err_q;
    state_d = state_q;
    case (state_q)
      IDLE:         state_d = !accept ? IDLE : err_d ? RESP :
                              (bus.req_we && bus.req_funct3 == F3_W) ? WRITE : READ;
      READ:         state_d = we_q ? MERGE : RESP;
      MERGE, WRITE: state_d = RESP;
      default:      state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_err   = bus.rsp_valid && err_q;
  assign bus.rsp_rdata = (bus.rsp_valid && !we_q && !err_q) ? ld_data : '0;
  assign bus.mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.mem_rw    = state_q == MERGE || state_q == WRITE;
  assign bus.mem_wdata = state_q == MERGE ? st_data : state_q == WRITE ? wdata_q : '0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized scoreboard bench for lsu_ctrl against a byte-level reference model
module tb_lsu_ctrl;
  import lsu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  lsu_if bus();
  lsu_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] mem [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  int total = 0, bad = 0, cyc = 0, acc_cyc = 0, wr_cnt = 0, wr_total = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, x, $time);
    end
  endtask
  function automatic logic [31:0] rdmem(input logic [31:0] a);
    return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'd0;
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_rw) mem[bus.mem_addr[31:2]] = bus.mem_wdata;
    else bus.mem_rdata <= rdmem(bus.mem_addr);
  end
  always @(negedge clk) begin
    if (bus.mem_rw) begin
      wr_total++;
      wr_cnt++;
    end
    if (rst_n && bus.req_valid && bus.req_ready) begin
      acc_cyc = cyc;
      wr_cnt = 0;
    end
    if (rst_n && bus.rsp_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected got rdata=%h err=%b exp=no response", bus.rsp_rdata, bus.rsp_err);
      end else begin
        e = q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        chk("rsp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
        chk("mem_writes", 32'(wr_cnt), 32'(e.wr));
      end
    end
  end
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    int off = int'(a[1:0]);
    logic ok;
    logic [31:0] w, m;
    exp_t x;
    ok = (we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6)) && (off % n == 0);
    w = ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'd0;
    m = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
    x.rdata = 32'd0;
    x.err = !ok;
    x.wr = (ok && we) ? 1 : 0;
    x.lat = !ok ? 1 : (we && n < 4) ? 3 : 2;
    if (ok && we) begin
      for (int i = 0; i < n; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
      ref_mem[a[31:2]] = w;
    end else if (ok) begin
      x.rdata = (w >> (8 * off)) & m;
      if (!f3[2] && n < 4 && x.rdata[8*n-1]) x.rdata = x.rdata | ~m;
    end
    q.push_back(x);
  endfunction
  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[31:2]] = w;
    ref_mem[a[31:2]] = w;
  endtask
  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = a;
    bus.req_wdata = wd;
  endtask
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int k = 0;
    model(we, f3, a, wd);
    @(posedge clk);
    #1 drive(we, f3, a, wd);
    @(negedge clk);
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int k = 0;
    while (q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int w0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_mem_rw", 32'(bus.mem_rw), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    put(32'h100, 32'h8000_00FF);
    issue(1'b0, F3_W, 32'h100, 32'd0);
    wait_idle();
    put(32'h100, 32'h80AA_BBCC);
    issue(1'b0, F3_B, 32'h103, 32'd0);
    issue(1'b0, F3_BU, 32'h103, 32'd0);
    wait_idle();
    put(32'h200, 32'h1122_3344);
    issue(1'b1, F3_B, 32'h201, 32'h0000_005A);
    wait_idle();
    chk("sb_word", rdmem(32'h200), 32'h1122_5A44);
    put(32'h200, 32'h1122_3344);
    issue(1'b1, F3_H, 32'h202, 32'h0000_BEEF);
    wait_idle();
    chk("sh_word", rdmem(32'h200), 32'hBEEF_3344);
    issue(1'b1, F3_W, 32'h204, 32'hDEAD_BEEF);
    issue(1'b0, F3_W, 32'h204, 32'd0);
    wait_idle();
    chk("sw_word", rdmem(32'h204), 32'hDEAD_BEEF);
    issue(1'b0, F3_W, 32'h102, 32'd0);
    issue(1'b1, F3_H, 32'h101, 32'hFFFF_FFFF);
    issue(1'b0, 3'b011, 32'h100, 32'd0);
    wait_idle();
    chk("err_no_write", rdmem(32'h100), 32'h80AA_BBCC);
    put(32'h200, 32'h1122_3344);
    @(posedge clk);
    #1 drive(1'b1, F3_B, 32'h201, 32'h0000_00A5);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    chk("abort_busy", 32'(bus.req_ready), 32'd0);
    w0 = wr_total;
    rst_n = 1'b0;
    #1 chk("abort_ready_async", 32'(bus.req_ready), 32'd1);
    chk("abort_mem_rw", 32'(bus.mem_rw), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_writes", 32'(wr_total - w0), 32'd0);
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_word", rdmem(32'h200), 32'h1122_3344);
    issue(1'b0, F3_W, 32'h200, 32'd0);
    wait_idle();
    for (int i = 0; i < 16; i++) put(32'h100 + 32'(4 * i), $urandom);
    for (int i = 0; i < 300; i++)
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'h100 + 32'($urandom_range(0, 63)), $urandom);
    wait_idle();
    for (int i = 0; i < 16; i++) chk("final_mem", rdmem(32'h100 + 32'(4 * i)), ref_mem[30'(32'h40 + 32'(i))]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
